// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter.
//                Includes the FSM state encoding, the register offsets inside
//                the two-word window, and the STATUS bit positions.
//                Optional feature macro: UART_PARITY_EN (adds the PARITY state
//                and the parity capability bit).
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_uart_pkg;

    // Transmitter FSM encoding. ST_PARITY is only entered when the parity
    // feature is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Register offsets relative to BASE_ADDR
    localparam logic [31:0] c_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] c_STATUS_OFS = 32'h0000_0004;

    // STATUS bit positions
    localparam int c_STAT_FULL       = 0;
    localparam int c_STAT_EMPTY      = 1;
    localparam int c_STAT_SHIFTING   = 2;
    localparam int c_STAT_OVF        = 3;
    localparam int c_STAT_COUNT_LSB  = 4;
    localparam int c_STAT_COUNT_W    = 4;
    localparam int c_STAT_PARITY_CAP = 8;

endpackage
`default_nettype wire

// File: rtl/mmio_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_tx_fifo
//  Description : Small synchronous first-word-fall-through FIFO holding bytes
//                waiting to be serialised. dout always shows the oldest entry.
//                A push into a full FIFO is accepted only when a pop happens
//                in the same cycle; otherwise it is dropped.
//  Ports       : clk, reset (async, active-high), push, pop, din -> dout,
//                full, empty, count (0..2**FIFO_AW)
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_tx_fifo
#(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);
    import mmio_uart_pkg::*;

    localparam int                c_DEPTH    = 2**FIFO_AW;
    localparam logic [FIFO_AW:0]  c_FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [WIDTH-1:0]   r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == c_FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped UART transmitter. Byte stores to BASE+0 are
//                queued in a FIFO and sent as 8N1 frames on tx (8E1 when
//                UART_PARITY_EN is defined). BASE+4 is a combinational
//                STATUS register; writing bit3=1 clears the sticky overflow.
//  Ports       : clk, reset (async, active-high), memwrite, address,
//                write_data -> read_data (STATUS), hit (window decode),
//                tx (serial out, idles high), busy
//  Macro       : UART_PARITY_EN - inserts an even-parity bit before STOP
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_uart_tx
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        tx,
    output logic        busy
);
    import mmio_uart_pkg::*;

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    // ---------------- bus decode ----------------
    logic        w_sel_data;
    logic        w_sel_status;
    logic        w_push_req;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic [31:0] w_status;
    logic        w_unused;

    // ---------------- FIFO ----------------
    logic [7:0]         w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FIFO_AW:0]   w_fifo_count;
    logic               w_pop;

    // ---------------- transmitter ----------------
    uart_state_e        r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_ovf;
    logic               w_bit_end;
`ifdef UART_PARITY_EN
    logic               r_parity;
`endif

    assign w_sel_data   = (address == BASE_ADDR + c_TXDATA_OFS);
    assign w_sel_status = (address == BASE_ADDR + c_STATUS_OFS);
    assign hit          = w_sel_data || w_sel_status;
    assign w_push_req   = memwrite && w_sel_data;

    // Only the low byte (and bit3 on STATUS writes) carry meaning.
    assign w_unused = &{1'b0, write_data[31:8]};

    assign w_bit_end = (r_bit_cnt == c_CNT_LAST);
    // Pop when idle, or at the end of STOP so the next frame follows with no gap.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    mmio_tx_fifo #(
        .WIDTH   (8),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (write_data[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Overflow: a push that the FIFO had to drop. Setting wins over clearing.
    assign w_ovf_set = w_push_req && w_fifo_full && !w_pop;
    assign w_ovf_clr = memwrite && w_sel_status && write_data[c_STAT_OVF];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    if (w_pop) begin
                        r_shift  <= w_fifo_dout;
                        r_tx     <= 1'b0;
                        r_state  <= ST_START;
`ifdef UART_PARITY_EN
                        r_parity <= ^w_fifo_dout;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= ST_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= ST_STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (w_pop) begin
                            r_shift  <= w_fifo_dout;
                            r_tx     <= 1'b0;
                            r_state  <= ST_START;
`ifdef UART_PARITY_EN
                            r_parity <= ^w_fifo_dout;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_status                                         = '0;
        w_status[c_STAT_FULL]                            = w_fifo_full;
        w_status[c_STAT_EMPTY]                           = w_fifo_empty;
        w_status[c_STAT_SHIFTING]                        = (r_state != ST_IDLE);
        w_status[c_STAT_OVF]                             = r_ovf;
        w_status[c_STAT_COUNT_LSB +: c_STAT_COUNT_W]     = c_STAT_COUNT_W'(w_fifo_count);
`ifdef UART_PARITY_EN
        w_status[c_STAT_PARITY_CAP]                      = 1'b1;
`endif
    end

    assign read_data = w_sel_status ? w_status : 32'h0;
    assign tx        = r_tx;
    assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx. A line monitor decodes
//                frames from tx by mid-bit sampling; expected bytes, bit
//                values and status words are derived from the register map
//                and framing rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam int          C    = 4;
`ifdef UART_PARITY_EN
    localparam int          NB   = 11;
    localparam logic [31:0] PCAP = 32'h0000_0100;
`else
    localparam int          NB   = 10;
    localparam logic [31:0] PCAP = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;
    logic        tx;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_AW      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- line monitor ----------------
    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         start;
    } frame_t;

    frame_t     rx_q[$];
    bit         m_act = 1'b0;
    int         m_t   = 0;
    int         m_start = 0;
    bit         m_ok  = 1'b1;
    logic [7:0] m_byte = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            m_act <= 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act   <= 1'b1;
                m_t     <= 1;
                m_start <= cyc;
                m_ok    <= 1'b1;
            end
        end else begin
            m_t <= m_t + 1;
            if ((m_t % C) == C / 2) begin
                if (m_t / C == 0) begin
                    if (tx !== 1'b0) m_ok <= 1'b0;
                end else if (m_t / C <= 8) begin
                    m_byte[m_t / C - 1] <= tx;
`ifdef UART_PARITY_EN
                end else if (m_t / C == 9) begin
                    if (tx !== ^m_byte) m_ok <= 1'b0;
`endif
                end else begin
                    rx_q.push_back('{data: m_byte, ok: m_ok && (tx === 1'b1), start: m_start});
                    m_act <= 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite   = 1'b1;
        address    = a;
        write_data = d;
        @(negedge clk);
        memwrite   = 1'b0;
    endtask

    // Value on the line during bit slot j of a frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One isolated frame: latency, mid-bit values, length and busy timing
    task automatic frame_seq(input logic [7:0] b);
        rx_q.delete();
        bus_write(BASE, {24'hC0FFEE, b});
        address = BASE + 32'h4;
        #1;
        check("tx_before_fall", {31'h0, tx}, 32'h1);
        check("busy_queued", {31'h0, busy}, 32'h1);
        for (int k = 0; k <= NB * C; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("tx_fall_latency", {31'h0, tx}, 32'h0);
                check("status_shifting", read_data, 32'h0000_0006 | PCAP);
            end
            if ((k % C) == C / 2 && (k / C) < NB)
                check($sformatf("bit%0d_of_%h", k / C, b), {31'h0, tx}, {31'h0, frame_bit(b, k / C)});
            if (k == NB * C - 1)
                check("busy_last_cycle", {31'h0, busy}, 32'h1);
            if (k == NB * C) begin
                check("busy_after_frame", {31'h0, busy}, 32'h0);
                check("tx_idle_after", {31'h0, tx}, 32'h1);
            end
        end
        check("frame_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            check("frame_data", {24'h0, rx_q[0].data}, {24'h0, b});
            check("frame_ok", {31'h0, rx_q[0].ok}, 32'h1);
        end
    endtask

    // ---------------- decode vectors ----------------
    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    logic [7:0]  exp_q[$];
    logic [31:0] decoy;
    int unsigned op;
    bit          low_seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{BASE,                1'b1, 32'h0};
        vecs[1] = '{BASE + 32'h4,        1'b1, 32'h2 | PCAP};
        vecs[2] = '{BASE + 32'h8,        1'b0, 32'h0};
        vecs[3] = '{BASE + 32'h1,        1'b0, 32'h0};
        vecs[4] = '{BASE - 32'h4,        1'b0, 32'h0};
        vecs[5] = '{BASE | 32'h0001_0004, 1'b0, 32'h0};
        vecs[6] = '{32'h0,               1'b0, 32'h0};

        reset      = 1'b1;
        memwrite   = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state after a long idle
        repeat (50) @(negedge clk);
        address = BASE + 32'h4;
        #1;
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_status", read_data, 32'h2 | PCAP);

        // Window decode and read mux
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            address = vecs[i].addr;
            #1;
            check($sformatf("hit_%h", vecs[i].addr), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
            check($sformatf("rd_%h", vecs[i].addr), read_data, vecs[i].exp_rd);
        end

        // Single frames
        frame_seq(8'hA5);
        frame_seq(8'h07);

        // Six back-to-back stores into a depth-4 FIFO
        rx_q.delete();
        @(negedge clk);
        memwrite = 1'b1;
        address  = BASE;
        for (int i = 1; i <= 6; i++) begin
            write_data = i;
            @(negedge clk);
        end
        memwrite = 1'b0;
        address  = BASE + 32'h4;
        #1;
        check("status_full_ovf", read_data, 32'h4D | PCAP);
        bus_write(BASE + 32'h4, 32'hFFFF_FFF7);
        address = BASE + 32'h4;
        #1;
        check("status_ovf_kept", read_data, 32'h4D | PCAP);
        bus_write(BASE + 32'h4, 32'h0000_0008);
        address = BASE + 32'h4;
        #1;
        check("status_ovf_cleared", read_data, 32'h45 | PCAP);
        for (int w = 0; w < NB * C * 6 + 50 && rx_q.size() < 5; w++) @(negedge clk);
        repeat (C) @(negedge clk);
        check("ovf_frames", rx_q.size(), 5);
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            check($sformatf("ovf_data%0d", i), {24'h0, rx_q[i].data}, i + 1);
            check($sformatf("ovf_ok%0d", i), {31'h0, rx_q[i].ok}, 32'h1);
            if (i > 0)
                check($sformatf("ovf_gap%0d", i), rx_q[i].start - rx_q[i-1].start, NB * C);
        end
        repeat (NB * C) @(negedge clk);
        #1;
        check("ovf_no_sixth", rx_q.size(), 5);
        check("ovf_idle_busy", {31'h0, busy}, 32'h0);
        check("ovf_idle_status", read_data, 32'h2 | PCAP);

        // Randomised traffic with decoy writes
        rx_q.delete();
        exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            for (int w = 0; w < NB * C * 3 && (exp_q.size() - rx_q.size()) >= 4; w++)
                @(negedge clk);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            op = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0:       decoy = BASE + 32'h8;
                1:       decoy = BASE + 32'h1;
                2:       decoy = BASE - 32'h4;
                default: decoy = BASE + 32'h4;
            endcase
            @(negedge clk);
            memwrite   = 1'b1;
            write_data = $urandom;
            if (op < 4) begin
                address = BASE;
                exp_q.push_back(write_data[7:0]);
            end else begin
                address = decoy;
            end
            @(negedge clk);
            memwrite = 1'b0;
        end
        for (int w = 0; w < exp_q.size() * NB * C + 200 && rx_q.size() < exp_q.size(); w++)
            @(negedge clk);
        check("rand_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("rand_data%0d", i), {24'h0, rx_q[i].data}, {24'h0, exp_q[i]});
            check($sformatf("rand_ok%0d", i), {31'h0, rx_q[i].ok}, 32'h1);
        end

        // Reset in the middle of the data bits
        repeat (NB * C) @(negedge clk);
        rx_q.delete();
        bus_write(BASE, 32'h3C);
        repeat (4 * C) @(negedge clk);
        #2;
        reset = 1'b1;
        address = BASE + 32'h4;
        #1;
        check("rst_tx_now", {31'h0, tx}, 32'h1);
        check("rst_busy_now", {31'h0, busy}, 32'h0);
        check("rst_status_now", read_data, 32'h2 | PCAP);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        low_seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        #1;
        check("rst_no_residual", {31'h0, low_seen}, 32'h0);
        check("rst_no_frames", rx_q.size(), 0);
        check("rst_status_after", read_data, 32'h2 | PCAP);
        check("rst_busy_after", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus (memwrite, address, write_data, read_data).
- Accepts byte stores from the core, buffers them in a small FIFO and serializes each as an 8N1 frame on `tx`.
- Supplies a combinational status word for loads; top level muxes it in when `hit`=1.
- Sits beside dmem in the top level.

Parameters:
- BASE_ADDR, 32'h0000_FF00, word-aligned base of the 2-register window.
- CLKS_PER_BIT, 16, clock cycles per serial bit, minimum 2.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  store strobe from core.
- address  input  32  byte address from core.
- write_data  input  32  store data from core.
- read_data  output  32  status word, combinational.
- hit  output  1  address is inside the window; combinational.
- tx  output  1  serial line, idles high, registered.
- busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Register map:
  - BASE+0 TXDATA, write-only; push write_data[7:0].
  - BASE+4 STATUS.
- STATUS read layout:
  - bit0 full, bit1 empty, bit2 shifting (FSM not IDLE), bit3 overflow (sticky).
  - bits[7:4] FIFO count, zero-extended.
  - Other bits 0.
- STATUS write: write_data[3]=1 clears overflow; other bits ignored.
- hit = (address == BASE_ADDR) || (address == BASE_ADDR+4). Full 32-bit compare, no aliasing.
- read_data = STATUS when address == BASE_ADDR+4, else 0. No side effect on read.
- Push: on rising clk when memwrite && address==BASE_ADDR. If FIFO full and no pop in the same cycle, the byte is dropped and overflow sets.
- Simultaneous push and pop while full: both occur, count unchanged, overflow not set.
- Simultaneous overflow-clear and new overflow in the same cycle: overflow ends set.
- FSM states: IDLE, START, DATA, STOP. Bit counter counts 0..CLKS_PER_BIT-1; bit index counts 0..7.
  - IDLE: tx=1. If FIFO non-empty, pop into shift register, tx<=0, go START.
  - START: hold CLKS_PER_BIT cycles, then tx<=shift[0], go DATA.
  - DATA: each CLKS_PER_BIT cycles shift right, LSB first. After bit 7, tx<=1, go STOP.
  - STOP: hold CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop, tx<=0, go START (no idle gap); else go IDLE.
- Latency: store at edge N into an empty FIFO with FSM in IDLE → tx falls after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- busy = (state != IDLE) || !empty.
- FIFO pointers wrap modulo depth. Count is FIFO_AW+1 bits, range 0..depth.
- Reset, including mid-frame:
  - Immediately: tx=1, state IDLE, FIFO emptied, overflow=0, counters 0, busy=0.
  - Any partial frame is abandoned.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11*CLKS_PER_BIT cycles.
- STATUS bit8 reads 1 when the macro is defined, 0 when it is undefined.
- Undefined: plain 8N1 framing; no parity logic is synthesized.

Decomposition:
- Package mmio_uart_pkg holds:
  - FSM state encoding constants.
  - Register offsets (TXDATA_OFS=0, STATUS_OFS=4).
  - STATUS bit positions (FULL, EMPTY, SHIFTING, OVF, COUNT_LSB, PARITY_CAP).
- One sub-module, mmio_tx_fifo: synchronous FIFO parameterized by width 8 and FIFO_AW.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-high reset.

Test Plan:
- Reset then idle 50 cycles → tx=1, busy=0, STATUS=32'h0000_0002 (empty).
- Store 32'hA5 to BASE+0 with CLKS_PER_BIT=4 → tx falls one cycle after the store edge.
  - Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1, then stop=1.
  - Frame lasts 40 cycles; busy drops after it.
- Six back-to-back stores 0x01..0x06 with depth 4 → STATUS shows full, then overflow=1.
  - Exactly 5 frames are emitted (first byte popped before fill), 0x01..0x05, contiguous with no idle gap.
- Write 32'h8 to BASE+4 after overflow → bit3 reads 0 next cycle; other status unchanged.
- Assert reset in the middle of the DATA bits → tx=1 immediately.
  - After release: STATUS=32'h2 and no residual frame.
- With UART_PARITY_EN, store 32'h07 → parity bit=1, frame 11*CLKS_PER_BIT cycles, STATUS bit8=1.
  - Load from BASE+8 → hit=0, read_data=0.
